// File: rtl/knn_pkg.sv
// Shared definitions for the k-nearest-neighbour top-K block: state encoding
// and the width derivations used by the datapath and the sorted list.
package knn_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } knn_state_e;

  function automatic int knn_clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  // Two squared (DATA_W+1)-bit differences summed never exceed 2*DATA_W+2 bits.
  function automatic int knn_dist_w(input int data_w);
    return 2 * data_w + 2;
  endfunction

  function automatic int knn_sel_w(input int k);
    return (knn_clog2(k) < 1) ? 1 : knn_clog2(k);
  endfunction

endpackage

// File: rtl/knn_dist.sv
// Squared Euclidean distance between a training point and the test point,
// registered once together with its label and a valid flag.
module knn_dist
  import knn_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int LABEL_W = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              i_flush,
  input  logic                              i_vld,
  input  logic [DATA_W-1:0]                 i_x,
  input  logic [DATA_W-1:0]                 i_y,
  input  logic [DATA_W-1:0]                 i_test_x,
  input  logic [DATA_W-1:0]                 i_test_y,
  input  logic [LABEL_W-1:0]                i_label,
  output logic [knn_dist_w(DATA_W)-1:0]     o_dist_p1,
  output logic [LABEL_W-1:0]                o_label_p1,
  output logic                              o_vld_p1
);

  localparam int DIST_W = knn_dist_w(DATA_W);
  localparam int EXT_W  = DIST_W - DATA_W - 1;

  logic signed [DATA_W:0]   w_dx_p0;
  logic signed [DATA_W:0]   w_dy_p0;
  logic signed [DIST_W-1:0] w_dxe_p0;
  logic signed [DIST_W-1:0] w_dye_p0;
  logic        [DIST_W-1:0] w_sqx_p0;
  logic        [DIST_W-1:0] w_sqy_p0;
  logic        [DIST_W-1:0] w_dist_p0;

  logic [DIST_W-1:0]  r_dist_p1;
  logic [LABEL_W-1:0] r_label_p1;
  logic               r_vld_p1;

  assign w_dx_p0  = $signed({i_x[DATA_W-1], i_x}) - $signed({i_test_x[DATA_W-1], i_test_x});
  assign w_dy_p0  = $signed({i_y[DATA_W-1], i_y}) - $signed({i_test_y[DATA_W-1], i_test_y});
  assign w_dxe_p0 = {{EXT_W{w_dx_p0[DATA_W]}}, w_dx_p0};
  assign w_dye_p0 = {{EXT_W{w_dy_p0[DATA_W]}}, w_dy_p0};
  assign w_sqx_p0 = $unsigned(w_dxe_p0 * w_dxe_p0);
  assign w_sqy_p0 = $unsigned(w_dye_p0 * w_dye_p0);
  assign w_dist_p0 = w_sqx_p0 + w_sqy_p0;

  // p0 -> p1: distance and label registered with their valid
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_dist_p1  <= '0;
      r_label_p1 <= '0;
      r_vld_p1   <= 1'b0;
    end else begin
      r_vld_p1 <= i_vld & ~i_flush;
      if (i_vld) begin
        r_dist_p1  <= w_dist_p0;
        r_label_p1 <= i_label;
      end
    end
  end

  assign o_dist_p1  = r_dist_p1;
  assign o_label_p1 = r_label_p1;
  assign o_vld_p1   = r_vld_p1;

endmodule

// File: rtl/knn_topk.sv
// Streaming top-K nearest-neighbour selector: control FSM plus a sorted
// list of the K closest training points seen since the last start.
module knn_topk
  import knn_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int K       = 4,
  parameter int LABEL_W = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic [DATA_W-1:0]               test_x,
  input  logic [DATA_W-1:0]               test_y,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [DATA_W-1:0]               in_x,
  input  logic [DATA_W-1:0]               in_y,
  input  logic [LABEL_W-1:0]              in_label,
  input  logic                            in_last,
  output logic                            busy,
  output logic                            done,
  output logic [knn_sel_w(K):0]           num_valid,
  input  logic [knn_sel_w(K)-1:0]         rd_sel,
  output logic [knn_dist_w(DATA_W)-1:0]   rd_dist,
  output logic [LABEL_W-1:0]              rd_label,
  output logic                            rd_valid
);

  localparam int DIST_W = knn_dist_w(DATA_W);
  localparam int SEL_W  = knn_sel_w(K);
  localparam logic [SEL_W:0] NUM_K = (SEL_W + 1)'(K);

  knn_state_e         r_state;
  logic [DATA_W-1:0]  r_test_x;
  logic [DATA_W-1:0]  r_test_y;

  logic               w_accept;
  logic [DIST_W-1:0]  w_dist_p1;
  logic [LABEL_W-1:0] w_label_p1;
  logic               w_vld_p1;

  logic [DIST_W-1:0]  r_dist  [K];
  logic [LABEL_W-1:0] r_label [K];
  logic [K-1:0]       r_valid;
  logic [SEL_W:0]     r_num;
  logic [K-1:0]       w_gt;
  logic [31:0]        w_sel;

  // start wins over a same-cycle acceptance
  assign w_accept = in_valid & in_ready & ~start;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= ST_IDLE;
      r_test_x <= '0;
      r_test_y <= '0;
      in_ready <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        r_state  <= ST_RUN;
        r_test_x <= test_x;
        r_test_y <= test_y;
        in_ready <= 1'b1;
        busy     <= 1'b1;
      end else begin
        case (r_state)
          ST_RUN: begin
            if (w_accept && in_last) begin
              r_state  <= ST_DRAIN;
              in_ready <= 1'b0;
            end
          end
          ST_DRAIN: begin
            if (!w_vld_p1) begin
              r_state <= ST_DONE;
              busy    <= 1'b0;
              done    <= 1'b1;
            end
          end
          ST_DONE: r_state <= ST_IDLE;
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  knn_dist #(
    .DATA_W  (DATA_W),
    .LABEL_W (LABEL_W)
  ) u_dist (
    .clk        (clk),
    .rst        (rst),
    .i_flush    (start),
    .i_vld      (w_accept),
    .i_x        (in_x),
    .i_y        (in_y),
    .i_test_x   (r_test_x),
    .i_test_y   (r_test_y),
    .i_label    (in_label),
    .o_dist_p1  (w_dist_p1),
    .o_label_p1 (w_label_p1),
    .o_vld_p1   (w_vld_p1)
  );

  // Empty slots count as farther than anything; the list is sorted so w_gt is 0..01..1.
  always_comb begin
    w_gt = '0;
    for (int i = 0; i < K; i++) begin
      w_gt[i] = !r_valid[i] || (r_dist[i] > w_dist_p1);
    end
  end

  // p1 -> p2: insert before the first strictly greater entry, shift the tail down
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < K; i++) begin
        r_dist[i]  <= '0;
        r_label[i] <= '0;
      end
      r_valid <= '0;
      r_num   <= '0;
    end else if (start) begin
      r_valid <= '0;
      r_num   <= '0;
    end else if (w_vld_p1 && w_gt[K-1]) begin
      if (w_gt[0]) begin
        r_dist[0]  <= w_dist_p1;
        r_label[0] <= w_label_p1;
        r_valid[0] <= 1'b1;
      end
      for (int i = 1; i < K; i++) begin
        if (w_gt[i-1]) begin
          r_dist[i]  <= r_dist[i-1];
          r_label[i] <= r_label[i-1];
          r_valid[i] <= r_valid[i-1];
        end else if (w_gt[i]) begin
          r_dist[i]  <= w_dist_p1;
          r_label[i] <= w_label_p1;
          r_valid[i] <= 1'b1;
        end
      end
      if (r_num != NUM_K) begin
        r_num <= r_num + 1'b1;
      end
    end
  end

  assign num_valid = r_num;
  assign w_sel     = 32'(rd_sel);

  always_comb begin
    rd_dist  = '0;
    rd_label = '0;
    rd_valid = 1'b0;
    for (int i = 0; i < K; i++) begin
      if (w_sel == 32'(i)) begin
        rd_dist  = r_dist[i];
        rd_label = r_label[i];
        rd_valid = r_valid[i];
      end
    end
  end

endmodule

// File: tb/tb_knn_topk.sv
// Bench for knn_topk: a sort-based reference of the K nearest points plus a
// timestamped control model, compared every cycle, with literal anchors.
module tb_knn_topk;

  localparam int DATA_W  = 16;
  localparam int K       = 4;
  localparam int LABEL_W = 8;
  localparam int DIST_W  = 2 * DATA_W + 2;
  localparam int SEL_W   = 2;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                start = 1'b0;
  logic [DATA_W-1:0]   test_x = '0;
  logic [DATA_W-1:0]   test_y = '0;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic [DATA_W-1:0]   in_x = '0;
  logic [DATA_W-1:0]   in_y = '0;
  logic [LABEL_W-1:0]  in_label = '0;
  logic                in_last = 1'b0;
  logic                busy;
  logic                done;
  logic [SEL_W:0]      num_valid;
  logic [SEL_W-1:0]    rd_sel = '0;
  logic [DIST_W-1:0]   rd_dist;
  logic [LABEL_W-1:0]  rd_label;
  logic                rd_valid;

  always #5 clk = ~clk;

  knn_topk #(
    .DATA_W  (DATA_W),
    .K       (K),
    .LABEL_W (LABEL_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .test_x    (test_x),
    .test_y    (test_y),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .in_y      (in_y),
    .in_label  (in_label),
    .in_last   (in_last),
    .busy      (busy),
    .done      (done),
    .num_valid (num_valid),
    .rd_sel    (rd_sel),
    .rd_dist   (rd_dist),
    .rd_label  (rd_label),
    .rd_valid  (rd_valid)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Reference: every accepted point since the last start, with its accept edge.
  int     cyc = 0;
  bit     running = 1'b0;
  int     last_at = -1;
  longint mtx = 0;
  longint mty = 0;
  longint q_dist[$];
  int     q_lab[$];
  int     q_at[$];
  bit     used[256];

  longint m_dist[K];
  int     m_lab[K];
  bit     m_vld[K];
  int     m_num;
  longint s_dist[K];
  int     s_lab[K];
  bit     s_vld[K];
  int     s_num;
  int     done_cnt = 0;

  initial forever begin
    longint dx, dy;
    @(posedge clk or negedge rst);
    if (rst !== 1'b1) begin
      running = 1'b0;
      last_at = -1;
      mtx = 0;
      mty = 0;
      q_dist.delete();
      q_lab.delete();
      q_at.delete();
    end else begin
      cyc++;
      if (start) begin
        running = 1'b1;
        last_at = -1;
        mtx = longint'($signed(test_x));
        mty = longint'($signed(test_y));
        q_dist.delete();
        q_lab.delete();
        q_at.delete();
      end else if (running && in_valid) begin
        dx = longint'($signed(in_x)) - mtx;
        dy = longint'($signed(in_y)) - mty;
        q_dist.push_back(dx * dx + dy * dy);
        q_lab.push_back(int'(in_label));
        q_at.push_back(cyc);
        if (in_last) begin
          running = 1'b0;
          last_at = cyc;
        end
      end
    end
  end

  initial forever begin
    int  n, best;
    bit  e_busy, e_done;
    @(negedge clk);
    n = q_dist.size();
    for (int j = 0; j < 256; j++) used[j] = 1'b0;
    m_num = 0;
    for (int r = 0; r < K; r++) begin
      best = -1;
      for (int j = 0; j < n; j++) begin
        if (!used[j] && q_at[j] <= cyc - 1 && (best < 0 || q_dist[j] < q_dist[best])) best = j;
      end
      if (best >= 0) begin
        used[best] = 1'b1;
        m_vld[r]  = 1'b1;
        m_dist[r] = q_dist[best];
        m_lab[r]  = q_lab[best];
        m_num++;
      end else begin
        m_vld[r]  = 1'b0;
        m_dist[r] = 0;
        m_lab[r]  = 0;
      end
    end
    e_busy = running || (last_at >= 0 && cyc < last_at + 2);
    e_done = !running && last_at >= 0 && cyc == last_at + 2;
    chk("in_ready", longint'(in_ready), longint'(running));
    chk("busy", longint'(busy), longint'(e_busy));
    chk("done", longint'(done), longint'(e_done));
    chk("num_valid", longint'(num_valid), longint'(m_num));
    if (done === 1'b1) done_cnt++;
    for (int i = 0; i < K; i++) begin
      rd_sel = SEL_W'(i);
      #1;
      chk($sformatf("rd_valid[%0d]", i), longint'(rd_valid), longint'(m_vld[i]));
      if (m_vld[i]) begin
        chk($sformatf("rd_dist[%0d]", i), longint'(rd_dist), m_dist[i]);
        chk($sformatf("rd_label[%0d]", i), longint'(rd_label), longint'(m_lab[i]));
      end else if (rst !== 1'b1) begin
        chk($sformatf("rst_dist[%0d]", i), longint'(rd_dist), 0);
        chk($sformatf("rst_label[%0d]", i), longint'(rd_label), 0);
      end
      s_dist[i] = longint'(rd_dist);
      s_lab[i]  = int'(rd_label);
      s_vld[i]  = rd_valid;
    end
    s_num = int'(num_valid);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int tx, input int ty);
    start  = 1'b1;
    test_x = DATA_W'(tx);
    test_y = DATA_W'(ty);
    tick();
    start = 1'b0;
  endtask

  task automatic send(input int x, input int y, input int lab, input bit last);
    in_valid = 1'b1;
    in_x     = DATA_W'(x);
    in_y     = DATA_W'(y);
    in_label = LABEL_W'(lab);
    in_last  = last;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) tick();
  endtask

  initial begin
    repeat (2) tick();
    chk("reset_busy", longint'(busy), 0);
    chk("reset_in_ready", longint'(in_ready), 0);
    chk("reset_done", longint'(done), 0);
    chk("reset_num", longint'(num_valid), 0);
    chk("reset_rd_valid", longint'(rd_valid), 0);
    chk("reset_rd_dist", longint'(rd_dist), 0);
    rst = 1'b1;
    tick();

    // basic ordering
    done_cnt = 0;
    do_start(0, 0);
    send(3, 4, 1, 1'b0);
    send(1, 1, 2, 1'b0);
    send(-2, 0, 3, 1'b0);
    send(5, 5, 4, 1'b0);
    send(0, 1, 5, 1'b1);
    idle(6);
    chk("t1_model_d0", m_dist[0], 1);
    chk("t1_model_l3", longint'(m_lab[3]), 1);
    chk("t1_d0", s_dist[0], 1);
    chk("t1_l0", longint'(s_lab[0]), 5);
    chk("t1_d1", s_dist[1], 2);
    chk("t1_l1", longint'(s_lab[1]), 2);
    chk("t1_d2", s_dist[2], 4);
    chk("t1_l2", longint'(s_lab[2]), 3);
    chk("t1_d3", s_dist[3], 25);
    chk("t1_l3", longint'(s_lab[3]), 1);
    chk("t1_num", longint'(s_num), 4);
    chk("t1_done_cnt", longint'(done_cnt), 1);

    // tie, after an empty stretch in RUN
    done_cnt = 0;
    do_start(0, 0);
    idle(3);
    send(1, 0, 1, 1'b0);
    send(0, 1, 2, 1'b1);
    idle(6);
    chk("t2_d0", s_dist[0], 1);
    chk("t2_l0", longint'(s_lab[0]), 1);
    chk("t2_d1", s_dist[1], 1);
    chk("t2_l1", longint'(s_lab[1]), 2);
    chk("t2_num", longint'(s_num), 2);
    chk("t2_v2", longint'(s_vld[2]), 0);
    chk("t2_done_cnt", longint'(done_cnt), 1);

    // extreme coordinates
    do_start(-32768, -32768);
    send(32767, 32767, 9, 1'b1);
    idle(6);
    chk("t3_model_d0", m_dist[0], 64'd8589672450);
    chk("t3_d0", s_dist[0], 64'd8589672450);
    chk("t3_num", longint'(s_num), 1);

    // restart with a point in stage 1 and another offered alongside start
    do_start(0, 0);
    send(1, 1, 7, 1'b0);
    in_valid = 1'b1;
    in_x = DATA_W'(3);
    in_y = DATA_W'(3);
    in_label = LABEL_W'(6);
    do_start(0, 0);
    send(2, 0, 8, 1'b1);
    idle(6);
    chk("t4_num", longint'(s_num), 1);
    chk("t4_d0", s_dist[0], 4);
    chk("t4_l0", longint'(s_lab[0]), 8);

    // reset while draining
    done_cnt = 0;
    do_start(1, 1);
    send(2, 2, 1, 1'b0);
    send(3, 3, 2, 1'b1);
    #1;
    rst = 1'b0;
    #1;
    chk("t5_busy", longint'(busy), 0);
    chk("t5_in_ready", longint'(in_ready), 0);
    chk("t5_done", longint'(done), 0);
    chk("t5_num", longint'(num_valid), 0);
    chk("t5_rd_valid", longint'(rd_valid), 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    idle(4);
    chk("t5_no_done", longint'(done_cnt), 0);
    do_start(0, 0);
    send(0, 2, 3, 1'b1);
    idle(6);
    chk("t5_done_cnt", longint'(done_cnt), 1);
    chk("t5_d0", s_dist[0], 4);
    chk("t5_l0", longint'(s_lab[0]), 3);

    // full-rate stream with small coordinates so ties occur
    done_cnt = 0;
    do_start(int'($urandom_range(0, 6)) - 3, int'($urandom_range(0, 6)) - 3);
    for (int i = 0; i < 20; i++) begin
      send(int'($urandom_range(0, 12)) - 6, int'($urandom_range(0, 12)) - 6, i + 1, i == 19);
    end
    idle(6);
    chk("t6_done_cnt", longint'(done_cnt), 1);
    chk("t6_num", longint'(s_num), 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
